pulse_stretcher_hs: RTL and testbench
=====================================

Name: pulse_stretcher_hs

Overview:
- Converts a one-cycle strobe into a held level. This is the inverse of the level-to-pulse edge detector used by the DP_CTRL FSMs.
- On a strobe, level_out is held high for a programmable minimum number of cycles. If ACK_REQ=1, it stays high until the consumer acknowledges.
- Sits between FSM control strobes and slower or multi-cycle consumers (MAC enable, load windows) in DP_CTRL.

Parameters:
- CNT_W, 8: width of len_in and of the hold counter.
- ACK_REQ, 1: 1 = level released only after hold expiry AND ack; 0 = ack_in ignored.
- DROP_W, 4: width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pulse_in  in  1  one-cycle request strobe.
- len_in  in  CNT_W  hold length L in cycles; sampled only when a strobe is accepted; 0 treated as 1.
- ack_in  in  1  consumer acknowledge (level, sampled each edge).
- level_out  out  1  stretched level, registered.
- busy  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle strobe coincident with the first low cycle of level_out.
- drop_cnt  out  DROP_W  strobes rejected while busy; saturates at all-ones.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; level_out=0, busy=0, done_o=0, drop_cnt=0; internal cnt=0, ack_seen=0. Reset mid-hold drops level_out on that same edge; no done_o is generated.
- States: IDLE, HOLD, WAIT_ACK. All outputs registered; no combinational input-to-output path.
- IDLE, pulse_in=1 at edge k:
  - capture Leff = max(len_in,1); cnt <= Leff-1.
  - level_out <= 1, busy <= 1, state <= HOLD.
  - Latency: level_out high in the cycle after edge k.
- HOLD:
  - Any edge with ack_in=1 sets ack_seen.
  - If cnt != 0: cnt decrements each edge.
  - At the edge with cnt == 0 (edge k+Leff):
    - ACK_REQ=0, or ack_seen=1, or ack_in=1: level_out <= 0, busy <= 0, done_o <= 1, ack_seen <= 0, state <= IDLE.
    - Otherwise: state <= WAIT_ACK, level_out stays 1.
  - Minimum high time is exactly Leff cycles.
- WAIT_ACK: at the first edge with ack_in=1, level_out <= 0, busy <= 0, done_o <= 1, state <= IDLE.
- done_o is high for exactly one cycle, then returns to 0.
- Mandatory gap: level_out is low for at least one cycle between two holds. In the cycle where done_o=1, state is IDLE, so a pulse_in at the following edge is accepted.
- pulse_in=1 at any edge where state != IDLE (including the releasing edge) is dropped: drop_cnt increments by 1, saturating, and never wraps.
- ack_in while in IDLE: ignored; ack_seen is not set.
- Changing len_in during HOLD has no effect.

Optional Feature:
- Macro: PULSE_STRETCH_QUEUE_EN.
- Defined:
  - A 2-bit saturating pending counter (max 3) replaces dropping. Strobes arriving while busy increment pending; drop_cnt counts only strobes arriving while pending==3.
  - In IDLE with pending>0 and no pulse_in, a new hold starts at that edge using the current len_in, and pending decrements.
  - If pulse_in and pending>0 coincide in IDLE, one hold starts and pending is left unchanged (the new strobe takes the queued slot).
  - The one-cycle low gap still applies.
- Undefined: behaviour exactly as above, with no pending logic synthesized.

Test Plan:
- Reset, then ACK_REQ=0, len_in=3, pulse_in at edge 10 -> level_out high after edges 10,11,12 (3 cycles), low after edge 13; done_o=1 only in the cycle after edge 13; busy mirrors level_out.
- ACK_REQ=1, len_in=2, pulse at edge 5, ack_in held 0 until edge 12 -> state WAIT_ACK after edge 7; level_out high through edge 11; low and done_o=1 after edge 12.
- ACK_REQ=1, len_in=4, ack_in pulse at edge 6 only, pulse at edge 5 -> ack_seen latched; level_out falls after edge 9 with no WAIT_ACK visit.
- len_in=0, pulse at edge 3 -> level_out high for exactly 1 cycle (after edge 3), low after edge 4.
- len_in=5, pulses at edges 1,2,3 (queue off) -> single 5-cycle hold; drop_cnt=2. Then 20 more busy strobes -> drop_cnt saturates at 15.
- rst asserted at edge 4 of a len_in=8 hold -> level_out=0, busy=0 after edge 4; done_o stays 0; pulse at edge 6 starts a fresh 8-cycle hold.

Source files
------------

// File: rtl/pulse_stretcher_hs.sv
// Stretches a one-cycle strobe into a level held for max(len_in,1) cycles, optionally until ack.
// Optional macro PULSE_STRETCH_QUEUE_EN queues up to three strobes that arrive while busy.
module pulse_stretcher_hs #(
    parameter int CNT_W   = 8,
    parameter int ACK_REQ = 1,
    parameter int DROP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  len_in,
    input  logic              ack_in,
    output logic              level_out,
    output logic              busy,
    output logic              done_o,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack_seen;
    logic              r_level;
    logic              r_busy;
    logic              r_done;
    logic [DROP_W-1:0] r_drop;

    state_t            w_state_nxt;
    logic              w_start;
    logic              w_release;
    logic              w_req;
    logic              w_busy_strobe;
    logic              w_drop;
    logic [CNT_W-1:0]  w_len_m1;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ack_seen_nxt;
    logic [DROP_W-1:0] w_drop_nxt;

    // Handshake: pulse_in is accepted only at an edge where the state is IDLE;
    // any strobe seen in HOLD/WAIT_ACK (including the releasing edge) is not a new hold.
    assign w_busy_strobe = pulse_in && (r_state != S_IDLE);
    assign w_len_m1      = (len_in == '0) ? '0 : len_in - CNT_W'(1);

`ifdef PULSE_STRETCH_QUEUE_EN
    logic [1:0] r_pending;
    logic [1:0] w_pending_nxt;

    assign w_req = pulse_in || (r_pending != 2'd0);

    always_comb begin
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;
        if (w_busy_strobe) begin
            if (r_pending != 2'd3) w_pending_nxt = r_pending + 2'd1;
            else                   w_drop        = 1'b1;
        end else if (r_state == S_IDLE && !pulse_in && r_pending != 2'd0) begin
            w_pending_nxt = r_pending - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pending <= 2'd0;
        else     r_pending <= w_pending_nxt;
    end
`else
    assign w_req  = pulse_in;
    assign w_drop = w_busy_strobe;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ack_seen <= 1'b0;
            r_level    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack_seen <= w_ack_seen_nxt;
            r_level    <= (w_state_nxt != S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_release;
            r_drop     <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    if (ACK_REQ == 0 || r_ack_seen || ack_in) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ack_in) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_ack_seen_nxt = r_ack_seen;
        w_drop_nxt     = r_drop;
        if (w_start)                              w_cnt_nxt = w_len_m1;
        else if (r_state == S_HOLD && r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        if (w_start || w_release)                 w_ack_seen_nxt = 1'b0;
        else if (r_state == S_HOLD && ack_in)     w_ack_seen_nxt = 1'b1;
        if (w_drop && r_drop != '1)               w_drop_nxt = r_drop + DROP_W'(1);
    end

    assign level_out = r_level;
    assign busy      = r_busy;
    assign done_o    = r_done;
    assign drop_cnt  = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_stretcher_hs.sv
// Directed bench for pulse_stretcher_hs: one instance with ACK_REQ=1, one with ACK_REQ=0, shared inputs.
module tb_pulse_stretcher_hs;

    localparam logic [31:0] ST_IDLE = 0;
    localparam logic [31:0] ST_HOLD = 1;
    localparam logic [31:0] ST_WAIT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic [7:0] len_in = 8'd0;
    logic       ack_in = 1'b0;

    logic       a_level, a_busy, a_done;
    logic [3:0] a_drop;
    logic [1:0] a_state;
    logic       n_level, n_busy, n_done;
    logic [3:0] n_drop;
    logic [1:0] n_state;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_stretcher_hs #(.CNT_W(8), .ACK_REQ(1), .DROP_W(4)) u_dut_ack (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len_in(len_in), .ack_in(ack_in),
        .level_out(a_level), .busy(a_busy), .done_o(a_done), .drop_cnt(a_drop),
        .dbg_state(a_state)
    );

    pulse_stretcher_hs #(.CNT_W(8), .ACK_REQ(0), .DROP_W(4)) u_dut_noack (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .len_in(len_in), .ack_in(ack_in),
        .level_out(n_level), .busy(n_busy), .done_o(n_done), .drop_cnt(n_drop),
        .dbg_state(n_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pulse_in = 1'b0;
        ack_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        do_reset();
        chk("rst_level", a_level, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_state", a_state, ST_IDLE);
        chk("rst_level_n", n_level, 0);

        // ACK_REQ=0, len 3: high for 3 cycles, done with first low cycle
        len_in = 8'd3; pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk("t1_lvl_k", n_level, 1);
        chk("t1_busy_k", n_busy, 1);
        chk("t1_done_k", n_done, 0);
        tick(); chk("t1_lvl_k1", n_level, 1);
        tick(); chk("t1_lvl_k2", n_level, 1);
        pulse_in = 1'b1;  // lands on the releasing edge: dropped
        tick();
        chk("t1_lvl_k3", n_level, 0);
        chk("t1_busy_k3", n_busy, 0);
        chk("t1_done_k3", n_done, 1);
        chk("t1_drop_rel", n_drop, 1);
        tick();  // the next strobe is accepted after the one-cycle gap
        pulse_in = 1'b0;
        chk("t1_done_k4", n_done, 0);
        chk("t1_restart", n_level, 1);

        // ACK_REQ=1, len 2, no ack until later: goes through WAIT_ACK
        do_reset();
        len_in = 8'd2; pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk("t2_state_e5", a_state, ST_HOLD);
        tick(); chk("t2_state_e6", a_state, ST_HOLD);
        tick(); chk("t2_state_e7", a_state, ST_WAIT);
        chk("t2_lvl_e7", a_level, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_lvl_wait", a_level, 1);
        end
        chk("t2_done_wait", a_done, 0);
        ack_in = 1'b1; tick(); ack_in = 1'b0;
        chk("t2_lvl_e12", a_level, 0);
        chk("t2_done_e12", a_done, 1);
        chk("t2_state_e12", a_state, ST_IDLE);
        tick(); chk("t2_done_e13", a_done, 0);

        // ACK_REQ=1, len 4, early ack latched: releases at hold expiry
        do_reset();
        len_in = 8'd4; pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        ack_in = 1'b1; tick(); ack_in = 1'b0;
        chk("t3_state_e6", a_state, ST_HOLD);
        tick(); chk("t3_state_e7", a_state, ST_HOLD);
        tick(); chk("t3_state_e8", a_state, ST_HOLD);
        chk("t3_lvl_e8", a_level, 1);
        tick();
        chk("t3_lvl_e9", a_level, 0);
        chk("t3_done_e9", a_done, 1);
        chk("t3_state_e9", a_state, ST_IDLE);

        // len 0 treated as 1
        do_reset();
        len_in = 8'd0; pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk("t4_lvl_e3", n_level, 1);
        tick();
        chk("t4_lvl_e4", n_level, 0);
        chk("t4_done_e4", n_done, 1);

        // Back-to-back strobes while busy are dropped; drop counter saturates
        do_reset();
        len_in = 8'd5; pulse_in = 1'b1;
        tick(); tick(); tick();
        pulse_in = 1'b0;
        chk("t5_drop2", n_drop, 2);
        tick(); chk("t5_lvl_e4", n_level, 1);
        tick(); chk("t5_lvl_e5", n_level, 1);
        tick();
        chk("t5_lvl_e6", n_level, 0);
        chk("t5_done_e6", n_done, 1);
        len_in = 8'd200; pulse_in = 1'b1; tick();
        for (int i = 0; i < 12; i++) tick();
        chk("t5_drop14", n_drop, 14);
        for (int i = 0; i < 8; i++) tick();
        pulse_in = 1'b0;
        chk("t5_drop_sat", n_drop, 15);
        chk("t5_lvl_long", n_level, 1);

        // Reset mid-hold, then a fresh 8-cycle hold
        do_reset();
        chk("t6_drop_clr", n_drop, 0);
        len_in = 8'd8; pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        tick(); tick();
        chk("t6_lvl_e3", n_level, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_lvl_rst", n_level, 0);
        chk("t6_busy_rst", n_busy, 0);
        chk("t6_done_rst", n_done, 0);
        tick(); chk("t6_done_e5", n_done, 0);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk("t6_lvl_e6", n_level, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t6_lvl_hold", n_level, 1);
        end
        tick();
        chk("t6_lvl_e14", n_level, 0);
        chk("t6_done_e14", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
